// File: rtl/twi_slave_ctrl.sv
// TWI/I2C responder: filtered pad inputs, START/STOP detection, 7-bit address match,
// byte receive/transmit with ACK/NACK and SCL stretching after every completed byte.
module twi_slave_ctrl #(
   parameter int FILTER_LEN = 3,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  scl_pad_i,
   input  logic                  sda_pad_i,
   input  logic                  slv_en,
   input  logic [ADDR_WIDTH-1:0] own_addr,
   input  logic                  ack_en,
   input  logic [7:0]            tx_data,
   input  logic                  int_clr,
   output logic                  scl_pad_o,
   output logic                  sda_pad_o,
   output logic [7:0]            rx_data,
   output logic                  rw_bit,
   output logic                  slv_int,
   output logic                  start_det,
   output logic                  stop_det,
   output logic                  master_nack,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_STRETCH, S_RX, S_RX_ACK, S_TX, S_TX_ACK
   } state_t;

   logic [1:0] pad_raw;
   logic [1:0] pad_filt;
   assign pad_raw = {sda_pad_i, scl_pad_i};

   // Index 0 = SCL, 1 = SDA; a level change must persist FILTER_LEN cycles to pass
   for (genvar gi = 0; gi < 2; gi++) begin : g_filt
      logic       sync1_q, sync2_q, filt_q;
      logic [3:0] cnt_q;
      always_ff @(posedge pclk or negedge presetn) begin
         if (!presetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
         end else begin
            sync1_q <= pad_raw[gi];
            sync2_q <= sync1_q;
            if (sync2_q == filt_q) begin
               cnt_q <= '0;
            end else if (cnt_q == 4'(FILTER_LEN - 1)) begin
               filt_q <= sync2_q;
               cnt_q  <= '0;
            end else begin
               cnt_q <= cnt_q + 4'd1;
            end
         end
      end
      assign pad_filt[gi] = filt_q;
   end

   logic       scl_f, sda_f, scl_prev_q, sda_prev_q;
   logic       scl_rise, scl_fall, start_c, stop_c, counting;
   state_t     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d, tx_shift_q, tx_shift_d;
   logic [7:0] rx_data_q, rx_data_d, byte_in;
   logic       ack_q, ack_d, scl_o_q, scl_o_d, sda_o_q, sda_o_d, rw_q, rw_d;
   logic       int_q, int_d, start_q, stop_q, mnack_q, mnack_d, busy_q, busy_d;

   assign scl_f    = pad_filt[0];
   assign sda_f    = pad_filt[1];
   assign scl_rise = scl_f & ~scl_prev_q;
   assign scl_fall = ~scl_f & scl_prev_q;
   assign start_c  = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
   assign stop_c   = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
   assign byte_in  = {shift_q, sda_f};
   assign counting = state_q inside {S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK};

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_shift_d = tx_shift_q;
      rx_data_d  = rx_data_q;
      ack_d      = ack_q;
      scl_o_d    = scl_o_q;
      sda_o_d    = sda_o_q;
      rw_d       = rw_q;
      int_d      = int_q;
      mnack_d    = mnack_q;
      busy_d     = busy_q;
      if (start_c) begin
         busy_d  = 1'b1;
         mnack_d = 1'b0;
      end else if (stop_c) begin
         busy_d = 1'b0;
      end
      if (!slv_en || stop_c) begin
         state_d = S_IDLE;
         scl_o_d = 1'b1;
         sda_o_d = 1'b1;
         int_d   = 1'b0;
      end else if (start_c) begin
         state_d   = S_ADDR;
         bit_cnt_d = '0;
         scl_o_d   = 1'b1;
         sda_o_d   = 1'b1;
         int_d     = 1'b0;
      end else begin
         if (scl_rise && counting) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = byte_in[6:0];
         end
         case (state_q)
            S_ADDR: begin
               if (scl_rise && bit_cnt_q == 4'd7) begin
                  rx_data_d = byte_in;
                  if (shift_q == own_addr && ack_en) rw_d = sda_f;
                  else state_d = S_IDLE;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  state_d = S_ADDR_ACK;
                  sda_o_d = 1'b0;
               end
            end
            S_ADDR_ACK: begin
               if (scl_fall) begin
                  state_d = S_STRETCH;
                  sda_o_d = 1'b1;
                  scl_o_d = 1'b0;
                  int_d   = 1'b1;
               end
            end
            S_STRETCH: begin
               if (int_clr) begin
                  scl_o_d   = 1'b1;
                  int_d     = 1'b0;
                  bit_cnt_d = '0;
                  if (rw_q) begin
                     tx_shift_d = tx_data[6:0];
                     sda_o_d    = tx_data[7];
                     state_d    = S_TX;
                  end else begin
                     state_d = S_RX;
                  end
               end
            end
            S_RX: begin
               if (scl_rise && bit_cnt_q == 4'd7) begin
                  rx_data_d = byte_in;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  state_d = S_RX_ACK;
                  sda_o_d = ~ack_en;
                  ack_d   = ack_en;
               end
            end
            S_RX_ACK: begin
               if (scl_fall) begin
                  sda_o_d = 1'b1;
                  if (ack_q) begin
                     state_d = S_STRETCH;
                     scl_o_d = 1'b0;
                     int_d   = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            S_TX: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_o_d = 1'b1;
                     state_d = S_TX_ACK;
                  end else begin
                     sda_o_d    = tx_shift_q[6];
                     tx_shift_d = {tx_shift_q[5:0], 1'b1};
                  end
               end
            end
            S_TX_ACK: begin
               if (scl_rise) begin
                  ack_d = ~sda_f;
                  if (sda_f) mnack_d = 1'b1;
               end else if (scl_fall) begin
                  if (ack_q) begin
                     state_d = S_STRETCH;
                     scl_o_d = 1'b0;
                     int_d   = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q    <= S_IDLE;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tx_shift_q <= '0;
         rx_data_q  <= '0;
         ack_q      <= 1'b0;
         scl_o_q    <= 1'b1;
         sda_o_q    <= 1'b1;
         rw_q       <= 1'b0;
         int_q      <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         mnack_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         scl_prev_q <= scl_f;
         sda_prev_q <= sda_f;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_shift_q <= tx_shift_d;
         rx_data_q  <= rx_data_d;
         ack_q      <= ack_d;
         scl_o_q    <= scl_o_d;
         sda_o_q    <= sda_o_d;
         rw_q       <= rw_d;
         int_q      <= int_d;
         start_q    <= start_c;
         stop_q     <= stop_c;
         mnack_q    <= mnack_d;
         busy_q     <= busy_d;
      end
   end

   assign scl_pad_o   = scl_o_q;
   assign sda_pad_o   = sda_o_q;
   assign rx_data     = rx_data_q;
   assign rw_bit      = rw_q;
   assign slv_int     = int_q;
   assign start_det   = start_q;
   assign stop_det    = stop_q;
   assign master_nack = mnack_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_twi_slave_ctrl.sv
// Bench for twi_slave_ctrl: a bit-level bus master on a wired-AND bus, with expected
// results derived from address/ACK/data rules per transaction.
module tb_twi_slave_ctrl;
   localparam int Q = 10;

   logic       pclk = 1'b0, presetn = 1'b0;
   logic       scl_m = 1'b1, sda_m = 1'b1, ovr = 1'b0;
   logic       slv_en = 1'b0, ack_en = 1'b1, int_clr = 1'b0;
   logic [6:0] own_addr = 7'h52;
   logic [7:0] tx_data = 8'h00;
   logic       scl_pad_o, sda_pad_o, rw_bit, slv_int, start_det, stop_det, master_nack, busy;
   logic [7:0] rx_data;
   logic       scl_bus, sda_bus;
   logic [7:0] dbuf [4];

   int n_cmp = 0, n_fail = 0, n_start = 0, n_stop = 0;

   // ovr lets a second bus agent force SCL high over our stretch (repeated START case)
   assign scl_bus = scl_m & (scl_pad_o | ovr);
   assign sda_bus = sda_m & sda_pad_o;

   always #5 pclk = ~pclk;

   twi_slave_ctrl #(.FILTER_LEN(3), .ADDR_WIDTH(7)) dut (
      .pclk(pclk), .presetn(presetn), .scl_pad_i(scl_bus), .sda_pad_i(sda_bus),
      .slv_en(slv_en), .own_addr(own_addr), .ack_en(ack_en), .tx_data(tx_data),
      .int_clr(int_clr), .scl_pad_o(scl_pad_o), .sda_pad_o(sda_pad_o), .rx_data(rx_data),
      .rw_bit(rw_bit), .slv_int(slv_int), .start_det(start_det), .stop_det(stop_det),
      .master_nack(master_nack), .busy(busy)
   );

   always @(posedge pclk) begin
      if (start_det) n_start <= n_start + 1;
      if (stop_det)  n_stop  <= n_stop + 1;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before 3ms");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge pclk);
         #1;
         n_cmp++;
         assert (dut.bit_cnt_q <= 4'd9) else begin
            n_fail++;
            $error("FAIL bit_cnt_max: observed %0d expected <= 9", dut.bit_cnt_q);
         end
      end
   endtask

   task automatic check_reset(input string p);
      chk({p, "_scl"}, scl_pad_o, 1);
      chk({p, "_sda"}, sda_pad_o, 1);
      chk({p, "_rx"}, rx_data, 0);
      chk({p, "_rw"}, rw_bit, 0);
      chk({p, "_int"}, slv_int, 0);
      chk({p, "_start"}, start_det, 0);
      chk({p, "_stop"}, stop_det, 0);
      chk({p, "_mnack"}, master_nack, 0);
      chk({p, "_busy"}, busy, 0);
   endtask

   task automatic wait_scl_high();
      int k = 0;
      while (scl_bus !== 1'b1 && k < 3000) begin tick(1); k++; end
      chk("scl_wait", scl_bus, 1);
   endtask

   task automatic wait_int();
      int k = 0;
      while (slv_int !== 1'b1 && k < 200) begin tick(1); k++; end
      chk("slv_int_set", slv_int, 1);
      chk("scl_stretch", scl_pad_o, 0);
   endtask

   task automatic pulse_int();
      int_clr = 1'b1;
      tick(1);
      int_clr = 1'b0;
   endtask

   task automatic clk_bit(input bit b, output bit s);
      sda_m = b;
      tick(Q);
      scl_m = 1'b1;
      wait_scl_high();
      tick(Q);
      s = sda_bus;
      tick(Q);
      scl_m = 1'b0;
      tick(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output bit ack);
      bit s;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
      clk_bit(1'b1, ack);
   endtask

   task automatic recv_byte(output logic [7:0] got, input bit nack);
      bit s;
      got = '0;
      for (int i = 0; i < 8; i++) begin clk_bit(1'b1, s); got = {got[6:0], s}; end
      clk_bit(nack, s);
   endtask

   task automatic do_start();
      tick(Q); sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
   endtask

   task automatic do_stop();
      sda_m = 1'b0; tick(Q); scl_m = 1'b1; wait_scl_high(); tick(Q); sda_m = 1'b1; tick(Q);
   endtask

   // One transaction: address byte, n data bytes from dbuf; expectations follow the bus rules
   task automatic xfer(input logic [7:0] abyte, input int n, input bit aen, input bit nack_last);
      bit s, match;
      logic [7:0] got;
      int st0, sp0;
      st0 = n_start; sp0 = n_stop;
      ack_en = aen;
      do_start();
      chk("busy_set", busy, 1);
      chk("mnack_clr", master_nack, 0);
      send_byte(abyte, s);
      match = (abyte[7:1] == own_addr) && aen;
      chk("addr_ack", s, !match);
      chk("rx_addr", rx_data, abyte);
      if (!match) begin
         tick(30);
         chk("no_int_addr", slv_int, 0);
         chk("scl_rel_addr", scl_pad_o, 1);
      end else begin
         wait_int();
         chk("rw_bit", rw_bit, abyte[0]);
         for (int i = 0; i < n; i++) begin
            if (abyte[0]) begin
               tx_data = dbuf[i];
               pulse_int();
               recv_byte(got, i == n - 1);
               chk("tx_byte", got, dbuf[i]);
               if (i == n - 1) begin
                  chk("mnack_set", master_nack, 1);
                  chk("sda_rel_rd", sda_pad_o, 1);
                  chk("no_int_rd", slv_int, 0);
               end else begin
                  wait_int();
               end
            end else begin
               if (nack_last && i == n - 1) ack_en = 1'b0;
               pulse_int();
               send_byte(dbuf[i], s);
               chk("data_ack", s, !ack_en);
               chk("rx_data", rx_data, dbuf[i]);
               if (ack_en) wait_int();
               else begin tick(30); chk("no_int_nack", slv_int, 0); end
            end
         end
      end
      if (slv_int) pulse_int();
      do_stop();
      chk("busy_clr", busy, 0);
      chk("start_cnt", n_start - st0, 1);
      chk("stop_cnt", n_stop - sp0, 1);
      if (match && abyte[0]) chk("mnack_sticky", master_nack, 1);
   endtask

   initial begin
      bit s;
      logic [7:0] got;
      int st0, sp0, cnt0;
      logic [7:0] ab;

      tick(3);
      check_reset("rst");
      presetn = 1'b1; slv_en = 1'b1;
      tick(20);

      // master write 0xA4 / 0x3C to own address 0x52
      dbuf[0] = 8'h3C;
      xfer(8'hA4, 1, 1'b1, 1'b0);
      // address mismatch
      xfer(8'hA6, 1, 1'b1, 1'b0);
      // master read of 0xC3 ending in NACK
      dbuf[0] = 8'hC3;
      xfer(8'hA5, 1, 1'b1, 1'b0);
      // data byte NACKed by ack_en=0
      dbuf[0] = 8'h11; dbuf[1] = 8'h22;
      xfer(8'hA4, 2, 1'b1, 1'b1);

      // long stretch held by software
      ack_en = 1'b1;
      do_start();
      send_byte(8'hA4, s);
      wait_int();
      cnt0 = 0;
      for (int i = 0; i < 500; i++) begin
         if (scl_pad_o == 1'b0) cnt0++;
         tick(1);
      end
      chk("stretch_len", cnt0, 500);
      int_clr = 1'b1;
      chk("scl_held_at_clr", scl_pad_o, 0);
      tick(1);
      int_clr = 1'b0;
      chk("scl_released", scl_pad_o, 1);
      chk("int_cleared", slv_int, 0);
      do_stop();

      // repeated START while stretching after a written byte
      st0 = n_start;
      do_start();
      send_byte(8'hA4, s);
      wait_int();
      pulse_int();
      send_byte(8'h77, s);
      chk("rs_data_ack", s, 0);
      wait_int();
      sda_m = 1'b1; tick(Q);
      ovr = 1'b1; scl_m = 1'b1; wait_scl_high(); tick(Q);
      sda_m = 1'b0; tick(Q);
      chk("rs_start_cnt", n_start - st0, 2);
      chk("rs_int_clr", slv_int, 0);
      chk("rs_scl_rel", scl_pad_o, 1);
      scl_m = 1'b0; tick(Q); ovr = 1'b0;
      send_byte(8'hA5, s);
      chk("rs_addr_ack", s, 0);
      wait_int();
      chk("rs_rw", rw_bit, 1);
      tx_data = 8'h96;
      pulse_int();
      recv_byte(got, 1'b1);
      chk("rs_tx", got, 8'h96);
      chk("rs_mnack", master_nack, 1);
      do_stop();

      // slave disabled during a stretch
      do_start();
      send_byte(8'hA4, s);
      wait_int();
      slv_en = 1'b0;
      tick(1);
      chk("dis_scl_rel", scl_pad_o, 1);
      chk("dis_int_clr", slv_int, 0);
      chk("dis_busy", busy, 1);
      slv_en = 1'b1;
      do_stop();
      chk("dis_busy_clr", busy, 0);

      // 2-cycle SDA glitch with SCL high
      st0 = n_start; sp0 = n_stop;
      sda_m = 1'b0; tick(2); sda_m = 1'b1; tick(20);
      chk("glitch_start", n_start - st0, 0);
      chk("glitch_stop", n_stop - sp0, 0);
      chk("glitch_busy", busy, 0);

      // randomized transactions
      for (int t = 0; t < 6; t++) begin
         own_addr = 7'($urandom);
         ab = {own_addr, 1'($urandom)};
         if ($urandom_range(0, 3) == 0) ab[7:1] = own_addr ^ 7'($urandom_range(1, 127));
         for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom);
         xfer(ab, 1 + $urandom_range(0, 2), $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0);
      end

      // asynchronous reset in the middle of a data byte
      own_addr = 7'h52; ack_en = 1'b1;
      do_start();
      send_byte(8'hA4, s);
      wait_int();
      pulse_int();
      for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
      chk("pre_rst_busy", busy, 1);
      presetn = 1'b0;
      #1;
      check_reset("midrst");
      scl_m = 1'b1; sda_m = 1'b1;
      tick(10);
      presetn = 1'b1;
      tick(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
